// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared widths, opcode/status encodings and the response record for the
// processor_unit command sequencer.
package alu_cmd_sequencer_pkg;

    localparam int DATA_W = 4;
    localparam int OPC_W  = 3;
    localparam int TAG_W  = 2;

    // processor_unit opcode[1:0] meaning; the sequencer passes opcodes through untouched
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;

    localparam int STAT_ZERO  = 0;
    localparam int STAT_CARRY = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_EXT   = 3;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] status;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_resp_fifo.sv
// First-word-fall-through response FIFO; the head entry is visible whenever
// the FIFO is non-empty and reads as zero when empty.
module seq_resp_fifo
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  rsp_t push_data,
    input  logic pop,
    output rsp_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    rsp_t           mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives one tagged command at a time into a processor_unit, captures its
// result/status after a fixed latency and queues them as in-order responses.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [OPC_W-1:0]  pu_opcode,
    output logic [DATA_W-1:0] pu_data_a,
    output logic [DATA_W-1:0] pu_data_b,
    input  logic [DATA_W-1:0] pu_result,
    input  logic [DATA_W-1:0] pu_status,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_status,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic [7:0]        op_count
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [TAG_W-1:0]  tag_reg;
    logic [DATA_W-1:0] last_result_reg;
    logic              accept;
    logic              capture;
    logic              fifo_full;
    logic              fifo_empty;
    rsp_t              push_data;
    rsp_t              head;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        cmd_ready     = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = !fifo_full;
                if (cmd_valid && !fifo_full) begin
                    accept        = 1'b1;
                    wait_cnt_next = WAIT_LOAD;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 4'd1;
                // Count of 1 means this edge is WAIT_CYCLES edges after the accept
                if (wait_cnt_reg == 4'd1) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pu_opcode       <= '0;
            pu_data_a       <= '0;
            pu_data_b       <= '0;
            tag_reg         <= '0;
            last_result_reg <= '0;
            op_count        <= '0;
        end else begin
            if (accept) begin
                pu_opcode <= cmd_opcode;
                pu_data_a <= cmd_chain ? last_result_reg : cmd_a;
                pu_data_b <= cmd_b;
                tag_reg   <= cmd_tag;
            end
            if (capture) begin
                last_result_reg <= pu_result;
                op_count        <= op_count + 8'd1;
            end
        end
    end

    assign push_data = '{result: pu_result, status: pu_status, tag: tag_reg};

    seq_resp_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .push_data(push_data),
        .pop      (rsp_valid && rsp_ready),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rsp_valid  = !fifo_empty;
    assign rsp_result = head.result;
    assign rsp_status = head.status;
    assign rsp_tag    = head.tag;
    assign busy       = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Two sequencers (latency 1 and 3) share one randomized command stream and are
// checked every cycle against a queue-based reference model plus literal pins.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int WC0   = 1;
    localparam int WC1   = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_opcode = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic       cmd_chain = 1'b0;
    logic [1:0] cmd_tag = '0;
    logic       rsp_ready = 1'b0;

    logic       cmd_ready_w  [2];
    logic [2:0] pu_opcode_w  [2];
    logic [3:0] pu_a_w       [2];
    logic [3:0] pu_b_w       [2];
    logic [3:0] pu_result_w  [2];
    logic [3:0] pu_status_w  [2];
    logic       rsp_valid_w  [2];
    logic [3:0] rsp_result_w [2];
    logic [3:0] rsp_status_w [2];
    logic [1:0] rsp_tag_w    [2];
    logic       busy_w       [2];
    logic [7:0] op_count_w   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // processor_unit stand-in: AND / OR / ADD with zero, carry, overflow, opcode[2]
    function automatic logic [3:0] pu_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op[1:0])
            2'b00:   return a & b;
            2'b01:   return a | b;
            default: return 4'(a + b);
        endcase
    endfunction

    function automatic logic [3:0] pu_stat(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = pu_res(op, a, b);
        return {op[2], op[1] && (a[3] == b[3]) && (r[3] != a[3]), s[4], r == 4'd0};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_pu
        assign pu_result_w[gi] = pu_res(pu_opcode_w[gi], pu_a_w[gi], pu_b_w[gi]);
        assign pu_status_w[gi] = pu_stat(pu_opcode_w[gi], pu_a_w[gi], pu_b_w[gi]);
    end

    alu_cmd_sequencer #(.WAIT_CYCLES(WC0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[0]),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .cmd_tag(cmd_tag), .pu_opcode(pu_opcode_w[0]), .pu_data_a(pu_a_w[0]),
        .pu_data_b(pu_b_w[0]), .pu_result(pu_result_w[0]), .pu_status(pu_status_w[0]),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready), .rsp_result(rsp_result_w[0]),
        .rsp_status(rsp_status_w[0]), .rsp_tag(rsp_tag_w[0]), .busy(busy_w[0]),
        .op_count(op_count_w[0])
    );

    alu_cmd_sequencer #(.WAIT_CYCLES(WC1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[1]),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .cmd_tag(cmd_tag), .pu_opcode(pu_opcode_w[1]), .pu_data_a(pu_a_w[1]),
        .pu_data_b(pu_b_w[1]), .pu_result(pu_result_w[1]), .pu_status(pu_status_w[1]),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready), .rsp_result(rsp_result_w[1]),
        .rsp_status(rsp_status_w[1]), .rsp_tag(rsp_tag_w[1]), .busy(busy_w[1]),
        .op_count(op_count_w[1])
    );

    // Reference model: remaining-latency counter, last result, op count and a
    // log of pushed responses consumed from index rn up to wn.
    int         m_cnt   [2];
    logic [2:0] m_opc   [2];
    logic [3:0] m_a     [2];
    logic [3:0] m_b     [2];
    logic [1:0] m_tag   [2];
    logic [3:0] m_last  [2];
    logic [7:0] m_count [2];
    int         wn      [2];
    int         rn      [2];
    logic [3:0] log_r   [2][1024];
    logic [3:0] log_s   [2][1024];
    logic [1:0] log_t   [2][1024];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]   <= 0;
                m_opc[i]   <= '0;
                m_a[i]     <= '0;
                m_b[i]     <= '0;
                m_tag[i]   <= '0;
                m_last[i]  <= '0;
                m_count[i] <= '0;
                wn[i]      <= 0;
                rn[i]      <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_ready && wn[i] != rn[i]) rn[i] <= rn[i] + 1;
                if (m_cnt[i] == 1) begin
                    log_r[i][wn[i] % 1024] <= pu_res(m_opc[i], m_a[i], m_b[i]);
                    log_s[i][wn[i] % 1024] <= pu_stat(m_opc[i], m_a[i], m_b[i]);
                    log_t[i][wn[i] % 1024] <= m_tag[i];
                    wn[i]      <= wn[i] + 1;
                    m_last[i]  <= pu_res(m_opc[i], m_a[i], m_b[i]);
                    m_count[i] <= m_count[i] + 8'd1;
                    m_cnt[i]   <= 0;
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end else if (cmd_valid && (wn[i] - rn[i]) < DEPTH) begin
                    m_opc[i] <= cmd_opcode;
                    m_a[i]   <= cmd_chain ? m_last[i] : cmd_a;
                    m_b[i]   <= cmd_b;
                    m_tag[i] <= cmd_tag;
                    m_cnt[i] <= (i == 0) ? WC0 : WC1;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic ev;
                int   h;
                ev = (wn[i] != rn[i]);
                h  = rn[i] % 1024;
                chk("cmd_ready", i, 8'(cmd_ready_w[i]), 8'(m_cnt[i] == 0 && (wn[i] - rn[i]) < DEPTH));
                chk("rsp_valid", i, 8'(rsp_valid_w[i]), 8'(ev));
                chk("rsp_result", i, 8'(rsp_result_w[i]), ev ? 8'(log_r[i][h]) : 8'd0);
                chk("rsp_status", i, 8'(rsp_status_w[i]), ev ? 8'(log_s[i][h]) : 8'd0);
                chk("rsp_tag", i, 8'(rsp_tag_w[i]), ev ? 8'(log_t[i][h]) : 8'd0);
                chk("busy", i, 8'(busy_w[i]), 8'(m_cnt[i] != 0 || ev));
                chk("op_count", i, op_count_w[i], m_count[i]);
                chk("pu_opcode", i, 8'(pu_opcode_w[i]), 8'(m_opc[i]));
                chk("pu_data_a", i, 8'(pu_a_w[i]), 8'(m_a[i]));
                chk("pu_data_b", i, 8'(pu_b_w[i]), 8'(m_b[i]));
            end
        end
    endtask

    // Offers a command until dut<inst> accepts it; returns 1 time unit after the accept edge
    task automatic send(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b,
                        input logic chain, input logic [1:0] tag, input int inst);
        logic acc;
        logic got;
        got        = 1'b0;
        cmd_opcode = opc;
        cmd_a      = a;
        cmd_b      = b;
        cmd_chain  = chain;
        cmd_tag    = tag;
        cmd_valid  = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            acc = cmd_ready_w[inst];
            @(posedge clk);
            #1;
            if (acc) got = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("send_accept", inst, 8'(got), 8'd1);
    endtask

    task automatic run_cmd(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b,
                           input logic chain, input logic [1:0] tag, input logic [3:0] exp_a,
                           input logic [3:0] exp_r, input logic [3:0] exp_s, input logic [7:0] exp_n);
        send(opc, a, b, chain, tag, 0);
        chk("lit_pu_opcode", 0, 8'(pu_opcode_w[0]), 8'(opc));
        chk("lit_pu_data_a", 0, 8'(pu_a_w[0]), 8'(exp_a));
        chk("lit_pu_data_b", 0, 8'(pu_b_w[0]), 8'(b));
        chk("lit_rsp_early", 0, 8'(rsp_valid_w[0]), 8'd0);
        @(posedge clk);
        #1;
        chk("lit_rsp_valid", 0, 8'(rsp_valid_w[0]), 8'd1);
        chk("lit_rsp_result", 0, 8'(rsp_result_w[0]), 8'(exp_r));
        chk("lit_rsp_status", 0, 8'(rsp_status_w[0]), 8'(exp_s));
        chk("lit_rsp_tag", 0, 8'(rsp_tag_w[0]), 8'(tag));
        chk("lit_op_count", 0, op_count_w[0], exp_n);
    endtask

    initial begin
        logic [1:0] exp_tags [5];
        int         k;
        logic       acc;
        exp_tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        fork
            monitor();
        join_none

        // Reset held with a command offered
        cmd_valid = 1'b1;
        cmd_a     = 4'h9;
        cmd_b     = 4'h6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pu_opcode", 0, 8'(pu_opcode_w[0]), 8'd0);
        chk("rst_pu_data_a", 0, 8'(pu_a_w[0]), 8'd0);
        chk("rst_pu_data_b", 0, 8'(pu_b_w[0]), 8'd0);
        chk("rst_rsp_valid", 0, 8'(rsp_valid_w[0]), 8'd0);
        chk("rst_op_count", 0, op_count_w[0], 8'd0);
        chk("rst_cmd_ready", 0, 8'(cmd_ready_w[0]), 8'd1);
        chk("rst_busy", 0, 8'(busy_w[0]), 8'd0);
        chk("rst_busy", 1, 8'(busy_w[1]), 8'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed operations on the latency-1 instance
        run_cmd(3'b000, 4'hC, 4'hA, 1'b0, 2'd1, 4'hC, 4'h8, 4'b0010, 8'd1);
        run_cmd(3'b001, 4'h3, 4'h4, 1'b0, 2'd0, 4'h3, 4'h7, 4'b0000, 8'd2);
        run_cmd(3'b100, 4'hE, 4'h5, 1'b1, 2'd2, 4'h7, 4'h5, 4'b1000, 8'd3);
        run_cmd(3'b000, 4'h5, 4'hA, 1'b0, 2'd3, 4'h5, 4'h0, 4'b0001, 8'd4);
        run_cmd(3'b100, 4'h5, 4'hA, 1'b0, 2'd1, 4'h5, 4'h0, 4'b1001, 8'd5);
        run_cmd(3'b010, 4'h7, 4'h1, 1'b0, 2'd2, 4'h7, 4'h8, 4'b0100, 8'd6);

        // Fill the FIFO with rsp_ready low; a fifth command must stall
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'b0, 2'(t), 0);
        end
        cmd_opcode = 3'b001;
        cmd_tag    = 2'd0;
        cmd_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_cmd_ready", 0, 8'(cmd_ready_w[0]), 8'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 30 && k < 5; cyc++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready_w[0];
            if (rsp_valid_w[0]) begin
                chk("pop_tag_order", 0, 8'(rsp_tag_w[0]), 8'(exp_tags[k]));
                k++;
            end
            @(posedge clk);
            #1;
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("pops_seen", 0, 8'(k), 8'd5);

        // Reset one edge after an accept on the latency-3 instance
        repeat (12) @(posedge clk);
        #1;
        send(3'b010, 4'h6, 4'h3, 1'b0, 2'd3, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_rsp_valid", 1, 8'(rsp_valid_w[1]), 8'd0);
            chk("abort_op_count", 1, op_count_w[1], 8'd0);
            chk("abort_cmd_ready", 1, 8'(cmd_ready_w[1]), 8'd1);
        end

        // Randomized traffic, checked by the per-cycle model comparison
        @(posedge clk);
        #1;
        for (int c = 0; c < 500; c++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_opcode = 3'($urandom);
            cmd_a      = 4'($urandom);
            cmd_b      = 4'($urandom);
            cmd_chain  = ($urandom_range(0, 2) == 0);
            cmd_tag    = 2'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
